// File: rtl/reg_dump_reader_if.sv
// Word stream from the register dump engine to the debug/trace sink.
// The master drives the dump word; the slave returns ready.
interface reg_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              dump_valid;
    logic              dump_ready;
    logic [DATA_W-1:0] dump_data;
    logic [ADDR_W-1:0] dump_addr;
    logic              dump_last;

    modport master (
        output dump_valid,
        output dump_data,
        output dump_addr,
        output dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_data,
        input  dump_addr,
        input  dump_last,
        output dump_ready
    );
endinterface

// File: rtl/reg_dump_reader.sv
// Walks register-file addresses 0..NUM_REGS-1 and streams each value on a valid/ready port.
// REG_DUMP_CHECKSUM_EN appends one XOR checksum word (dump_addr=0, dump_last=1).
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | rd_addr=idx, capture rd_data into the output word
//   SEND  | word valid, wait for handshake
//   CSUM  | checksum word valid (REG_DUMP_CHECKSUM_EN only)
//   DONE  | one-cycle done pulse
module reg_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    reg_dump_reader_if.master dump_bus,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
`ifdef REG_DUMP_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] idx;
    logic              valid_q;
    logic              last_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;
    logic              start_acc;
    logic              fetch_en;
    logic              word_acc;
    logic              handshake;
    logic              is_last_idx;
`ifdef REG_DUMP_CHECKSUM_EN
    logic              csum_acc;
    logic [DATA_W-1:0] csum;
`endif

    assign handshake   = valid_q && dump_bus.dump_ready;
    assign is_last_idx = (idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_acc  = 1'b0;
        fetch_en   = 1'b0;
        word_acc   = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_acc   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                fetch_en   = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                if (handshake) begin
                    word_acc = 1'b1;
                    if (!is_last_idx) begin
                        state_next = FETCH;
                    end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                        state_next = CSUM;
`else
                        state_next = DONE;
`endif
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: begin
                if (handshake) begin
                    csum_acc   = 1'b1;
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum    <= '0;
`endif
        end else begin
            if (start_acc) begin
                idx <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
                csum <= '0;
`endif
            end
            if (fetch_en) begin
                data_q  <= rd_data;
                addr_q  <= idx;
                valid_q <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                last_q  <= 1'b0;
`else
                last_q  <= is_last_idx;
`endif
            end
            if (word_acc) begin
                valid_q <= 1'b0;
                if (!is_last_idx) begin
                    idx <= idx + 1'b1;
                end
`ifdef REG_DUMP_CHECKSUM_EN
                csum <= csum ^ data_q;
                // The checksum word follows the last register with no FETCH gap.
                if (is_last_idx) begin
                    data_q  <= csum ^ data_q;
                    addr_q  <= '0;
                    last_q  <= 1'b1;
                    valid_q <= 1'b1;
                end
`endif
            end
`ifdef REG_DUMP_CHECKSUM_EN
            if (csum_acc) begin
                valid_q <= 1'b0;
            end
`endif
        end
    end

    assign rd_addr             = idx;
    assign busy                = (state != IDLE);
    assign done                = (state == DONE);
    assign dump_bus.dump_valid = valid_q;
    assign dump_bus.dump_data  = data_q;
    assign dump_bus.dump_addr  = addr_q;
    assign dump_bus.dump_last  = last_q;
endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized bench for reg_dump_reader with a cycle-level behavioural model of the dump sequence.
module tb_reg_dump_reader;
    localparam int N = 32;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int TOTAL = N + 1;
    localparam bit CK    = 1'b1;
`else
    localparam int TOTAL = N;
    localparam bit CK    = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic [31:0] regs [0:N-1];

    reg_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) dbus ();

    reg_dump_reader #(.NUM_REGS(N), .ADDR_W(5), .DATA_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .dump_bus (dbus),
        .busy     (busy),
        .done     (done)
    );

    assign rd_data = regs[rd_addr];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ready pattern: 0 = always high, 1 = one cycle in three, 2 = random
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       dbus.dump_ready = 1'b1;
            1:       dbus.dump_ready = (cyc % 3 == 0);
            default: dbus.dump_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // model: active dump, FETCH gap pending, done cycle, index of next expected word
    bit          m_active = 0;
    bit          m_fetch  = 0;
    bit          m_done   = 0;
    int          m_n      = 0;
    logic [31:0] m_csum   = '0;
    int          start_cyc = 0;
    int          got_n    = 0;
    logic [31:0] got_data [0:63];
    logic [4:0]  got_addr [0:63];
    logic        got_last [0:63];
    int          done_cnt = 0;
    int          done_lat = 0;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_valid", dbus.dump_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_last", dbus.dump_last, 0);
            chk("rst_data", dbus.dump_data, 0);
            chk("rst_addr", dbus.dump_addr, 0);
            chk("rst_rd_addr", rd_addr, 0);
            m_active = 0;
            m_fetch  = 0;
            m_done   = 0;
        end else begin
            chk("busy", busy, m_active);
            chk("done", done, m_done);
            chk("valid", dbus.dump_valid, m_active && !m_fetch && !m_done);
            if (m_active && m_fetch) chk("rd_addr", rd_addr, m_n);
            if (dbus.dump_valid && m_active && !m_fetch && !m_done) begin
                chk("word_data", dbus.dump_data, (m_n < N) ? regs[m_n] : m_csum);
                chk("word_addr", dbus.dump_addr, (m_n < N) ? m_n : 0);
                chk("word_last", dbus.dump_last, m_n == TOTAL - 1);
            end
            if (done) begin
                done_cnt++;
                done_lat = cyc - start_cyc;
            end
            if (!m_active) begin
                if (start) begin
                    m_active  = 1;
                    m_fetch   = 1;
                    m_n       = 0;
                    m_csum    = '0;
                    got_n     = 0;
                    start_cyc = cyc;
                end
            end else if (m_done) begin
                m_active = 0;
                m_done   = 0;
            end else if (m_fetch) begin
                m_fetch = 0;
            end else if (dbus.dump_ready) begin
                if (got_n < 64) begin
                    got_data[got_n] = dbus.dump_data;
                    got_addr[got_n] = dbus.dump_addr;
                    got_last[got_n] = dbus.dump_last;
                end
                got_n++;
                if (m_n < N) m_csum ^= regs[m_n];
                m_n++;
                if (m_n == TOTAL) m_done = 1;
                else if (m_n < N) m_fetch = 1;
            end
        end
    end

    // All drive tasks start and end at posedge+1.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_cnt;
        int k  = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk(name, done_cnt - d0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_words(input int n, input int budget);
        int k = 0;
        while (got_n < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk("wait_words", got_n >= n, 1);
        @(posedge clk); #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) regs[i] = $urandom;
    endtask

    initial begin
        int d0;
        int k;
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < N; i++) regs[i] = 32'hA500_0000 + i;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;

        // T1: ready high, literal sequence and latency
        rdy_mode = 0;
        pulse_start();
        wait_done("t1_done", 200);
        chk("t1_words", got_n, CK ? 33 : 32);
        chk("t1_first_data", got_data[0], 32'hA500_0000);
        chk("t1_first_addr", got_addr[0], 0);
        chk("t1_last_data", got_data[31], 32'hA500_001F);
        chk("t1_last_addr", got_addr[31], 31);
        chk("t1_last_flag31", got_last[31], !CK);
        chk("t1_last_flag30", got_last[30], 0);
        chk("t1_latency", done_lat, CK ? 66 : 65);

        // T2: ready one cycle in three
        rdy_mode = 1;
        d0 = done_cnt;
        pulse_start();
        wait_done("t2_done", 400);
        chk("t2_words", got_n, TOTAL);
        for (int i = 0; i < N; i++) begin
            chk("t2_seq_data", got_data[i], 32'hA500_0000 + i);
            chk("t2_seq_addr", got_addr[i], i);
        end

        // T3: start while busy is ignored
        rdy_mode = 2;
        fill_random();
        d0 = done_cnt;
        pulse_start();
        wait_words(10, 200);
        pulse_start();
        wait_done("t3_done", 600);
        repeat (6) @(posedge clk);
        #1;
        chk("t3_single_done", done_cnt - d0, 1);
        chk("t3_idle_after", busy, 0);
        chk("t3_words", got_n, TOTAL);

        // T4: reset during SEND on addr 7
        rdy_mode = 1;
        d0 = done_cnt;
        pulse_start();
        k = 0;
        while (!(dbus.dump_valid && dbus.dump_addr == 7 && !dbus.dump_ready) && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        chk("t4_reached_addr7", dbus.dump_addr, 7);
        #1 reset = 1'b1;
        #1;
        chk("t4_async_valid", dbus.dump_valid, 0);
        chk("t4_async_busy", busy, 0);
        @(negedge clk); #1;
        @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("t4_no_done", done_cnt - d0, 0);
        rdy_mode = 0;
        pulse_start();
        wait_done("t4_redump_done", 200);
        chk("t4_redump_words", got_n, TOTAL);
        chk("t4_redump_addr0", got_addr[0], 0);

        // T5: register written mid-dump shows its new value
        rdy_mode = 2;
        fill_random();
        pulse_start();
        wait_words(5, 200);
        regs[20] = 32'hDEAD_BEEF;
        wait_done("t5_done", 600);
        chk("t5_live_value", got_data[20], 32'hDEAD_BEEF);
        chk("t5_live_addr", got_addr[20], 20);

        // T6: start held high gives back-to-back dumps
        rdy_mode = 0;
        fill_random();
        d0 = done_cnt;
        start = 1'b1;
        k = 0;
        while (done_cnt < d0 + 2 && k < 400) begin
            @(negedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("t6_two_dumps", done_cnt - d0, 2);
        chk("t6_latency", done_lat, CK ? 66 : 65);
        repeat (4) @(posedge clk);
        #1;
        chk("t6_stopped", busy, 0);

`ifdef REG_DUMP_CHECKSUM_EN
        // T7: checksum word
        for (int i = 0; i < N; i++) regs[i] = i;
        pulse_start();
        wait_done("t7_done", 200);
        chk("t7_words", got_n, 33);
        chk("t7_csum_zero", got_data[32], 32'h0);
        chk("t7_csum_addr", got_addr[32], 0);
        chk("t7_csum_last", got_last[32], 1);
        regs[3] = 32'hFF;
        rdy_mode = 2;
        pulse_start();
        wait_done("t7b_done", 600);
        chk("t7_csum_fc", got_data[32], 32'hFC);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
